// File: rtl/ds_reg_write_sequencer.sv
// Write-port sequencer for the delta-sigma DAC register file: byte-pair word assembly,
// immediate writes, and deferred writes committed after pulse_done. Option: DS_SEQ_WATCHDOG_EN.
module ds_reg_write_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WDOG_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic [2:0]               addr_in,
  input  logic                     data_part_in,
  input  logic                     pulse_done,
  input  logic                     clr_ovf,
  output logic                     reg_we,
  output logic [1:0]               reg_addr,
  output logic [15:0]              reg_wdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     commit_pulse
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sreg_q;
  logic            dp, last;
  logic [7:0]      data_low_q;
  logic            word_valid, imm_wr, def_wr;
  logic [15:0]     word;
  logic [17:0]     mem_q [DEPTH];
  logic [17:0]     head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d, remaining_q, remaining_d;
  logic            push, drop, pop, last_pop, start;
  logic            pulse_q, wdog_fire;

  assign dp         = sreg_q[1];
  assign last       = sreg_q[0];
  assign word_valid = dp & ~last;
  assign word       = {data_in, data_low_q};
  assign imm_wr     = word_valid & ~addr_in[2];
  assign def_wr     = word_valid & addr_in[2];
  assign head       = mem_q[rd_ptr_q];

  // A same-cycle pop frees a slot for the incoming deferred write.
  assign push = def_wr & ((count_q != CntW'(DEPTH)) | pop);
  assign drop = def_wr & ~push;

  assign fifo_level = count_q;
  assign busy       = (state_q == StDrain);

`ifdef DS_SEQ_WATCHDOG_EN
  logic [WDOG_BITS-1:0] wdog_q;

  assign wdog_fire = (state_q == StIdle) && (wdog_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q != StIdle || count_q == '0 || start) begin
      wdog_q <= '0;
    end else if (!wdog_fire) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  // Without the watchdog, WDOG_BITS has no effect; this evaluates to zero for any sane width.
  assign wdog_fire = (WDOG_BITS == 0);
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pop         = 1'b0;
    last_pop    = 1'b0;
    start       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pulse_q && count_q != '0) begin
          start       = 1'b1;
          remaining_d = count_q;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        // Immediate writes own the port; the pop waits a cycle.
        if (remaining_q != '0 && !imm_wr) begin
          pop         = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CntW'(1)) begin
            last_pop = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {addr_in[1:0], word};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q       <= 3'b111;
      data_low_q   <= '0;
      pulse_q      <= 1'b0;
      state_q      <= StIdle;
      remaining_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_we       <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      overflow     <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      sreg_q      <= {data_part_in, sreg_q[2:1]};
      pulse_q     <= pulse_done | wdog_fire;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      if (!dp && last) begin
        data_low_q <= data_in;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      reg_we       <= imm_wr | pop;
      commit_pulse <= last_pop;
      if (imm_wr) begin
        reg_addr  <= addr_in[1:0];
        reg_wdata <= word;
      end else if (pop) begin
        reg_addr  <= head[17:16];
        reg_wdata <= head[15:0];
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds_reg_write_sequencer.sv
// Directed self-checking bench for ds_reg_write_sequencer (default build, DEPTH=4).
module tb_ds_reg_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic [2:0]  addr_in = '0;
  logic        data_part_in = 1'b1;
  logic        pulse_done = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        busy;
  logic        commit_pulse;

  int n_cmp = 0;
  int n_err = 0;

  ds_reg_write_sequencer #(.DEPTH(4), .WDOG_BITS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .addr_in      (addr_in),
    .data_part_in (data_part_in),
    .pulse_done   (pulse_done),
    .clr_ovf      (clr_ovf),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .busy         (busy),
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Low byte phase; leaves the high byte and rising strobe set up but not yet sampled.
  task automatic host_low(input logic [2:0] a, input logic [15:0] w);
    addr_in      = a;
    data_in      = w[7:0];
    data_part_in = 1'b0;
    repeat (3) step();
    data_in      = w[15:8];
    data_part_in = 1'b1;
  endtask

  // Returns just after edge k+1: the word is detected and registers at the next edge.
  task automatic send_word(input logic [2:0] a, input logic [15:0] w);
    host_low(a, w);
    step();
    step();
  endtask

  task automatic pulse();
    pulse_done = 1'b1;
    step();
    pulse_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, fifo_level, overflow, busy, commit_pulse} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {reg_we, reg_addr, reg_wdata, fifo_level, overflow, busy, commit_pulse});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_immediate();
    send_word(3'd2, 16'h1234);
    n_cmp++;
    if (reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL imm_early: reg_we got %b want 0", reg_we);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 2'd2, 16'h1234}) begin
      n_err++;
      $display("FAIL imm_write: got we=%b addr=%0d data=%h want we=1 addr=2 data=1234",
               reg_we, reg_addr, reg_wdata);
    end
    n_cmp++;
    if (fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL imm_level: got %0d want 0", fifo_level);
    end
    step();
    n_cmp++;
    if (reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL imm_single: reg_we got %b want 0", reg_we);
    end
  endtask

  task automatic test_deferred_batch();
    send_word(3'd5, 16'hAAAA);
    step();
    send_word(3'd7, 16'h5555);
    step();
    n_cmp++;
    if ({reg_we, fifo_level} !== {1'b0, 3'd2}) begin
      n_err++;
      $display("FAIL batch_queued: got we=%b level=%0d want we=0 level=2", reg_we, fifo_level);
    end
    pulse();
    step();
    n_cmp++;
    if ({busy, reg_we} !== 2'b10) begin
      n_err++;
      $display("FAIL batch_busy: got busy=%b we=%b want busy=1 we=0", busy, reg_we);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level} !==
        {1'b1, 2'd1, 16'hAAAA, 1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL batch_first: got we=%b addr=%0d data=%h commit=%b level=%0d want 1 1 aaaa 0 1",
               reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level} !==
        {1'b1, 2'd3, 16'h5555, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL batch_second: got we=%b addr=%0d data=%h commit=%b level=%0d want 1 3 5555 1 0",
               reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level);
    end
    step();
    n_cmp++;
    if ({busy, reg_we, commit_pulse} !== 3'b000) begin
      n_err++;
      $display("FAIL batch_done: got busy=%b we=%b commit=%b want 0 0 0", busy, reg_we, commit_pulse);
    end
  endtask

  task automatic test_empty_pulse();
    pulse();
    repeat (3) begin
      step();
      n_cmp++;
      if ({busy, reg_we, commit_pulse} !== 3'b000) begin
        n_err++;
        $display("FAIL empty_pulse: got busy=%b we=%b commit=%b want 0 0 0",
                 busy, reg_we, commit_pulse);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  exp_a [4];
    logic [15:0] exp_d [4];
    exp_a[0] = 2'd0; exp_d[0] = 16'hA001;
    exp_a[1] = 2'd1; exp_d[1] = 16'hA002;
    exp_a[2] = 2'd2; exp_d[2] = 16'hA003;
    exp_a[3] = 2'd3; exp_d[3] = 16'hA004;
    for (int i = 0; i < 5; i++) begin
      send_word(3'd4 + 3'(i % 4), 16'hA001 + 16'(i));
      step();
    end
    n_cmp++;
    if ({fifo_level, overflow} !== {3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_set: got level=%0d ovf=%b want level=4 ovf=1", fifo_level, overflow);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_cmp++;
    if ({fifo_level, overflow} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_clear: got level=%0d ovf=%b want level=4 ovf=0", fifo_level, overflow);
    end
    pulse();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({reg_we, reg_addr, reg_wdata, commit_pulse} !== {1'b1, exp_a[i], exp_d[i], i == 3}) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got we=%b addr=%0d data=%h commit=%b want 1 %0d %h %b",
                 i, reg_we, reg_addr, reg_wdata, commit_pulse, exp_a[i], exp_d[i], i == 3);
      end
    end
    step();
    n_cmp++;
    if ({busy, fifo_level, reg_we} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_done: got busy=%b level=%0d we=%b want 0 0 0", busy, fifo_level, reg_we);
    end
  endtask

  task automatic test_collision();
    send_word(3'd4, 16'h1111);
    step();
    send_word(3'd6, 16'h2222);
    step();
    host_low(3'd1, 16'hBEEF);
    pulse();
    step();
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, fifo_level, busy} !== {1'b1, 2'd1, 16'hBEEF, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL coll_imm: got we=%b addr=%0d data=%h level=%0d busy=%b want 1 1 beef 2 1",
               reg_we, reg_addr, reg_wdata, fifo_level, busy);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, commit_pulse} !== {1'b1, 2'd0, 16'h1111, 1'b0}) begin
      n_err++;
      $display("FAIL coll_pop1: got we=%b addr=%0d data=%h commit=%b want 1 0 1111 0",
               reg_we, reg_addr, reg_wdata, commit_pulse);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level} !==
        {1'b1, 2'd2, 16'h2222, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL coll_pop2: got we=%b addr=%0d data=%h commit=%b level=%0d want 1 2 2222 1 0",
               reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level);
    end
    step();
    n_cmp++;
    if ({busy, reg_we} !== 2'b00) begin
      n_err++;
      $display("FAIL coll_done: got busy=%b we=%b want 0 0", busy, reg_we);
    end
  endtask

  task automatic test_snapshot();
    send_word(3'd5, 16'h3333);
    step();
    host_low(3'd7, 16'h4444);
    pulse();
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL snap_busy: got %b want 1", busy);
    end
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level, busy} !==
        {1'b1, 2'd1, 16'h3333, 1'b1, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL snap_commit: got we=%b addr=%0d data=%h commit=%b level=%0d busy=%b want 1 1 3333 1 1 0",
               reg_we, reg_addr, reg_wdata, commit_pulse, fifo_level, busy);
    end
    repeat (20) step();
    n_cmp++;
    if ({fifo_level, reg_we, busy} !== {3'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL snap_stays: got level=%0d we=%b busy=%b want 1 0 0", fifo_level, reg_we, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      send_word(3'd4 + 3'(i), 16'hC001 + 16'(i));
      step();
    end
    n_cmp++;
    if (fifo_level !== 3'd4) begin
      n_err++;
      $display("FAIL rst_fill: got level=%0d want 4", fifo_level);
    end
    pulse();
    step();
    step();
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 2'd3, 16'h4444}) begin
      n_err++;
      $display("FAIL rst_first_pop: got we=%b addr=%0d data=%h want 1 3 4444",
               reg_we, reg_addr, reg_wdata);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_we, reg_addr, reg_wdata, fifo_level, overflow, busy, commit_pulse} !== 25'd0) begin
      n_err++;
      $display("FAIL rst_async: got %h want 0",
               {reg_we, reg_addr, reg_wdata, fifo_level, overflow, busy, commit_pulse});
    end
    step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      n_cmp++;
      if ({reg_we, commit_pulse, busy, fifo_level} !== 6'd0) begin
        n_err++;
        $display("FAIL rst_after: got we=%b commit=%b busy=%b level=%0d want 0 0 0 0",
                 reg_we, commit_pulse, busy, fifo_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_deferred_batch();
    test_empty_pulse();
    test_overflow();
    test_collision();
    test_snapshot();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
